// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the main-memory arbiter: state encoding,
// requester IDs, processor-level widths and the line-align helper.
package mem_arbiter_pkg;

    localparam int PROC_ARCH_BITS = 32;
    localparam int PROC_LINE_BITS = 128;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_IREAD  = 2'd1,
        ST_DREAD  = 2'd2,
        ST_DWRITE = 2'd3
    } arbState_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } reqId_t;

    // Clear the low offsetBits of an address so it points at the line start.
    function automatic logic [PROC_ARCH_BITS-1:0] lineAlign(
        input logic [PROC_ARCH_BITS-1:0] addr,
        input int                        offsetBits
    );
        logic [PROC_ARCH_BITS-1:0] mask;
        mask = '1;
        mask = mask << offsetBits;
        return addr & mask;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-port main-memory arbiter between the icache (fills) and the
// dcache (fills and writebacks). One line transaction at a time; the
// memory completion pulse is steered back to the owner, and a transaction
// that never completes is aborted by a timeout that sets a sticky flag.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ARCH_BITS        = PROC_ARCH_BITS,
    parameter int MEMORY_LINE_BITS = PROC_LINE_BITS,
    parameter int OFFSET_BITS      = 4,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        iReadReq,
    input  logic [ARCH_BITS-1:0]        iReadAddr,
    output logic [MEMORY_LINE_BITS-1:0] iReadLine,
    output logic                        iReadLineValid,

    input  logic                        dReadReq,
    input  logic [ARCH_BITS-1:0]        dReadAddr,
    output logic [MEMORY_LINE_BITS-1:0] dReadLine,
    output logic                        dReadLineValid,

    input  logic                        dWriteReq,
    input  logic [ARCH_BITS-1:0]        dWriteAddr,
    input  logic [MEMORY_LINE_BITS-1:0] dWriteLine,
    output logic                        dWriteAck,

    output logic                        memReq,
    output logic                        memWE,
    output logic [ARCH_BITS-1:0]        memAddr,
    output logic [MEMORY_LINE_BITS-1:0] memWLine,
    input  logic [MEMORY_LINE_BITS-1:0] memRLine,
    input  logic                        memRValid,
    input  logic                        memWAck,

    output logic                        errTimeout
);

    localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);

    arbState_t             state;
    arbState_t             stateNext;
    reqId_t                rrLast;
    logic [CNT_BITS-1:0]   timeoutCnt;

    logic                  grant;
    logic [ARCH_BITS-1:0]  grantAddr;
    logic                  done;
    logic                  timeoutHit;

    // State register, captured transaction registers, counter and error flag.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            rrLast     <= REQ_I;
            timeoutCnt <= '0;
            errTimeout <= 1'b0;
            // NOTE: the address/data capture registers are reset too because
            // they drive top-level outputs that must read 0 during reset.
            memAddr    <= '0;
            memWLine   <= '0;
        end else begin
            state <= stateNext;
            if (grant) begin
                memAddr    <= ARCH_BITS'(lineAlign(PROC_ARCH_BITS'(grantAddr), OFFSET_BITS));
                timeoutCnt <= '0;
                if (stateNext == ST_DWRITE) begin
                    memWLine <= dWriteLine;
                end
                if (stateNext == ST_IREAD) begin
                    rrLast <= REQ_I;
                end else if (stateNext == ST_DREAD) begin
                    rrLast <= REQ_D;
                end
            end else if (timeoutHit) begin
                timeoutCnt <= '0;
                errTimeout <= 1'b1;
            end else if (state != ST_IDLE && !done) begin
                timeoutCnt <= timeoutCnt + 1'b1;
            end
        end
    end

    // Arbitration, completion steering and timeout abort.
    // NOTE: every signal written here gets a default first so no latch is
    // inferred on paths that do not assign it.
    always_comb begin
        stateNext      = state;
        grant          = 1'b0;
        grantAddr      = '0;
        done           = 1'b0;
        timeoutHit     = 1'b0;
        memReq         = 1'b0;
        memWE          = 1'b0;
        iReadLineValid = 1'b0;
        dReadLineValid = 1'b0;
        dWriteAck      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (dWriteReq) begin
                    grant     = 1'b1;
                    grantAddr = dWriteAddr;
                    stateNext = ST_DWRITE;
                end else if (iReadReq && dReadReq) begin
                    grant = 1'b1;
                    if (rrLast == REQ_I) begin
                        grantAddr = dReadAddr;
                        stateNext = ST_DREAD;
                    end else begin
                        grantAddr = iReadAddr;
                        stateNext = ST_IREAD;
                    end
                end else if (iReadReq) begin
                    grant     = 1'b1;
                    grantAddr = iReadAddr;
                    stateNext = ST_IREAD;
                end else if (dReadReq) begin
                    grant     = 1'b1;
                    grantAddr = dReadAddr;
                    stateNext = ST_DREAD;
                end
            end
            ST_IREAD: begin
                memReq = 1'b1;
                if (memRValid) begin
                    iReadLineValid = 1'b1;
                    done           = 1'b1;
                    stateNext      = ST_IDLE;
                end
            end
            ST_DREAD: begin
                memReq = 1'b1;
                if (memRValid) begin
                    dReadLineValid = 1'b1;
                    done           = 1'b1;
                    stateNext      = ST_IDLE;
                end
            end
            ST_DWRITE: begin
                memReq = 1'b1;
                memWE  = 1'b1;
                if (memWAck) begin
                    dWriteAck = 1'b1;
                    done      = 1'b1;
                    stateNext = ST_IDLE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase

        // A busy cycle without completion that would bring the count to the
        // limit aborts the transaction with no completion pulse.
        if (state != ST_IDLE && !done && timeoutCnt == CNT_LAST) begin
            timeoutHit = 1'b1;
            stateNext  = ST_IDLE;
        end
    end

    // Fill data is passed straight through; only the valid pulses are gated
    // by ownership. Held at 0 while reset is asserted.
    assign iReadLine = rst ? '0 : memRLine;
    assign dReadLine = rst ? '0 : memRLine;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Inputs change on the falling edge,
// outputs are sampled 1 time unit later, away from the rising edge.
module tb_mem_arbiter;

    localparam int AB = 32;
    localparam int LB = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          iReadReq = 1'b0;
    logic [AB-1:0] iReadAddr = '0;
    logic [LB-1:0] iReadLine;
    logic          iReadLineValid;
    logic          dReadReq = 1'b0;
    logic [AB-1:0] dReadAddr = '0;
    logic [LB-1:0] dReadLine;
    logic          dReadLineValid;
    logic          dWriteReq = 1'b0;
    logic [AB-1:0] dWriteAddr = '0;
    logic [LB-1:0] dWriteLine = '0;
    logic          dWriteAck;
    logic          memReq;
    logic          memWE;
    logic [AB-1:0] memAddr;
    logic [LB-1:0] memWLine;
    logic [LB-1:0] memRLine = '0;
    logic          memRValid = 1'b0;
    logic          memWAck = 1'b0;
    logic          errTimeout;

    mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .iReadReq       (iReadReq),
        .iReadAddr      (iReadAddr),
        .iReadLine      (iReadLine),
        .iReadLineValid (iReadLineValid),
        .dReadReq       (dReadReq),
        .dReadAddr      (dReadAddr),
        .dReadLine      (dReadLine),
        .dReadLineValid (dReadLineValid),
        .dWriteReq      (dWriteReq),
        .dWriteAddr     (dWriteAddr),
        .dWriteLine     (dWriteLine),
        .dWriteAck      (dWriteAck),
        .memReq         (memReq),
        .memWE          (memWE),
        .memAddr        (memAddr),
        .memWLine       (memWLine),
        .memRLine       (memRLine),
        .memRValid      (memRValid),
        .memWAck        (memWAck),
        .errTimeout     (errTimeout)
    );

    always #5 clk = ~clk;

    int nCompared   = 0;
    int nMismatched = 0;

    localparam logic [LB-1:0] LINE_A5 = {16{8'hA5}};
    localparam logic [LB-1:0] LINE_3C = {16{8'h3C}};
    localparam logic [LB-1:0] LINE_WB = {8{16'h1122}};
    localparam logic [LB-1:0] LINE_XX = {4{32'hDEADBEEF}};

    task automatic checkVal(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic pulseSeen;
        logic dropSeen;

        // ---------------- reset ----------------
        #1 rst = 1'b1;
        nextCycle();
        memRLine = LINE_A5;
        settle();
        checkVal("rst_memReq", memReq, 0);
        checkVal("rst_errTimeout", errTimeout, 0);
        checkVal("rst_iReadLine", iReadLine, 0);
        checkVal("rst_memAddr", memAddr, 0);

        // ---------------- single icache fill ----------------
        nextCycle();
        rst = 1'b0; memRLine = '0;
        iReadReq = 1'b1; iReadAddr = 32'h0000_1234;
        settle();
        checkVal("t1_idle_memReq", memReq, 0);
        nextCycle(); settle();
        checkVal("t1_memReq", memReq, 1);
        checkVal("t1_memWE", memWE, 0);
        checkVal("t1_memAddr", memAddr, 32'h0000_1230);
        nextCycle(); settle();
        nextCycle();
        memRValid = 1'b1; memRLine = LINE_A5; iReadReq = 1'b0;
        settle();
        checkVal("t1_iValid", iReadLineValid, 1);
        checkVal("t1_iLine", iReadLine, LINE_A5);
        checkVal("t1_dValid", dReadLineValid, 0);
        nextCycle();
        memRValid = 1'b0;
        settle();
        checkVal("t1_after_memReq", memReq, 0);
        checkVal("t1_after_iValid", iReadLineValid, 0);

        // ---------------- round robin ties ----------------
        iReadReq = 1'b1; iReadAddr = 32'h0000_0104;
        dReadReq = 1'b1; dReadAddr = 32'h0000_0208;
        nextCycle(); settle();
        checkVal("rr1_addr_D", memAddr, 32'h0000_0200);
        nextCycle();
        memRValid = 1'b1; memRLine = LINE_3C;
        settle();
        checkVal("rr1_dValid", dReadLineValid, 1);
        checkVal("rr1_iValid", iReadLineValid, 0);
        checkVal("rr1_dLine", dReadLine, LINE_3C);
        nextCycle();
        memRValid = 1'b0;
        settle();
        checkVal("rr_gap_memReq", memReq, 0);
        nextCycle(); settle();
        checkVal("rr2_memReq", memReq, 1);
        checkVal("rr2_addr_I", memAddr, 32'h0000_0100);
        nextCycle();
        memRValid = 1'b1;
        settle();
        checkVal("rr2_iValid", iReadLineValid, 1);
        checkVal("rr2_dValid", dReadLineValid, 0);
        nextCycle();
        memRValid = 1'b0;
        settle();
        nextCycle(); settle();
        checkVal("rr3_addr_D", memAddr, 32'h0000_0200);
        nextCycle();
        memRValid = 1'b1; iReadReq = 1'b0; dReadReq = 1'b0;
        settle();
        checkVal("rr3_dValid", dReadLineValid, 1);
        nextCycle();
        memRValid = 1'b0;
        settle();

        // ---------------- writeback beats read ----------------
        dWriteReq = 1'b1; dWriteAddr = 32'h0000_0040; dWriteLine = LINE_WB;
        dReadReq = 1'b1; dReadAddr = 32'h0000_0300;
        nextCycle();
        dWriteLine = LINE_XX;
        settle();
        checkVal("wb_memReq", memReq, 1);
        checkVal("wb_memWE", memWE, 1);
        checkVal("wb_memAddr", memAddr, 32'h0000_0040);
        checkVal("wb_memWLine", memWLine, LINE_WB);
        nextCycle();
        memRValid = 1'b1;
        settle();
        checkVal("wb_rvalid_ignored", dReadLineValid, 0);
        checkVal("wb_still_busy", memWE, 1);
        nextCycle();
        memRValid = 1'b0; memWAck = 1'b1; dWriteReq = 1'b0;
        settle();
        checkVal("wb_ack", dWriteAck, 1);
        checkVal("wb_no_dValid", dReadLineValid, 0);
        nextCycle();
        memWAck = 1'b0;
        settle();
        checkVal("wb_gap_memReq", memReq, 0);
        checkVal("wb_gap_ack", dWriteAck, 0);
        nextCycle(); settle();
        checkVal("wb_then_read_memReq", memReq, 1);
        checkVal("wb_then_read_memWE", memWE, 0);
        checkVal("wb_then_read_addr", memAddr, 32'h0000_0300);
        nextCycle();
        memRValid = 1'b1; dReadReq = 1'b0;
        settle();
        checkVal("wb_then_read_dValid", dReadLineValid, 1);
        nextCycle();
        memRValid = 1'b0;
        settle();

        // ---------------- spurious pulses ----------------
        memRValid = 1'b1; memWAck = 1'b1;
        settle();
        checkVal("idle_rvalid_i", iReadLineValid, 0);
        checkVal("idle_rvalid_d", dReadLineValid, 0);
        checkVal("idle_wack", dWriteAck, 0);
        nextCycle();
        memRValid = 1'b0; memWAck = 1'b0;
        iReadReq = 1'b1; iReadAddr = 32'h0000_050F;
        settle();
        nextCycle();
        memWAck = 1'b1;
        settle();
        checkVal("iread_wack_ignored", dWriteAck, 0);
        checkVal("iread_wack_no_iValid", iReadLineValid, 0);
        nextCycle();
        memWAck = 1'b0;
        settle();
        checkVal("iread_remains", memReq, 1);
        checkVal("iread_addr", memAddr, 32'h0000_0500);
        nextCycle();
        memRValid = 1'b1; iReadReq = 1'b0;
        settle();
        checkVal("iread_done_iValid", iReadLineValid, 1);
        nextCycle();
        memRValid = 1'b0;
        settle();

        // ---------------- timeout ----------------
        dReadReq = 1'b1; dReadAddr = 32'h0000_060C;
        pulseSeen = 1'b0;
        dropSeen  = 1'b0;
        for (int j = 1; j <= 254; j++) begin
            nextCycle(); settle();
            if (iReadLineValid || dReadLineValid || dWriteAck) pulseSeen = 1'b1;
            if (!memReq) dropSeen = 1'b1;
        end
        checkVal("to_busy_held", dropSeen, 0);
        nextCycle(); settle();
        checkVal("to_busy255_memReq", memReq, 1);
        checkVal("to_busy255_err", errTimeout, 0);
        nextCycle(); settle();
        if (iReadLineValid || dReadLineValid || dWriteAck) pulseSeen = 1'b1;
        checkVal("to_idle_memReq", memReq, 0);
        checkVal("to_err_set", errTimeout, 1);
        checkVal("to_no_pulse", pulseSeen, 0);
        nextCycle(); settle();
        checkVal("to_regrant_memReq", memReq, 1);
        checkVal("to_regrant_addr", memAddr, 32'h0000_0600);
        nextCycle();
        memRValid = 1'b1; dReadReq = 1'b0;
        settle();
        checkVal("to_regrant_dValid", dReadLineValid, 1);
        checkVal("to_err_sticky", errTimeout, 1);
        nextCycle();
        memRValid = 1'b0;
        settle();

        // ---------------- reset mid-transaction ----------------
        dReadReq = 1'b1; dReadAddr = 32'h0000_07FF;
        nextCycle(); settle();
        checkVal("rstmid_busy", memReq, 1);
        checkVal("rstmid_addr", memAddr, 32'h0000_07F0);
        nextCycle();
        rst = 1'b1; memRValid = 1'b1;
        settle();
        checkVal("rstmid_memReq", memReq, 0);
        checkVal("rstmid_err", errTimeout, 0);
        checkVal("rstmid_dValid", dReadLineValid, 0);
        checkVal("rstmid_dLine", dReadLine, 0);
        nextCycle();
        rst = 1'b0; memRValid = 1'b0;
        settle();
        checkVal("rstrel_idle", memReq, 0);
        nextCycle(); settle();
        checkVal("rstrel_regrant", memReq, 1);
        checkVal("rstrel_addr", memAddr, 32'h0000_07F0);
        nextCycle();
        memRValid = 1'b1; dReadReq = 1'b0;
        settle();
        checkVal("rstrel_dValid", dReadLineValid, 1);
        nextCycle();
        memRValid = 1'b0;
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port main-memory arbiter shared by the instruction cache (line fills only) and the data cache (line fills plus dirty-line writebacks).
- Sits between both cache miss interfaces and the memory model.
- Serialises one line transaction at a time and steers the completion pulse back to the owner.
- Flags hung transactions with a timeout.

Parameters:
- ARCH_BITS, 32, address/word width.
- MEMORY_LINE_BITS, 128, line width on every line bus.
- OFFSET_BITS, 4, low address bits cleared to line-align memAddr.
- TIMEOUT_CYCLES, 255, max cycles waiting for a memory response before abort.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- iReadReq  in  1  icache fill request, level, held until served.
- iReadAddr  in  ARCH_BITS  icache miss address.
- iReadLine  out  MEMORY_LINE_BITS  fill data to icache.
- iReadLineValid  out  1  one-cycle fill-complete pulse.
- dReadReq  in  1  dcache fill request, level.
- dReadAddr  in  ARCH_BITS  dcache miss address.
- dReadLine  out  MEMORY_LINE_BITS  fill data to dcache.
- dReadLineValid  out  1  one-cycle pulse.
- dWriteReq  in  1  dcache writeback request, level.
- dWriteAddr  in  ARCH_BITS  writeback address.
- dWriteLine  in  MEMORY_LINE_BITS  writeback data.
- dWriteAck  out  1  one-cycle writeback-complete pulse.
- memReq  out  1  memory transaction active.
- memWE  out  1  1 = write, 0 = read.
- memAddr  out  ARCH_BITS  line-aligned address.
- memWLine  out  MEMORY_LINE_BITS  write data.
- memRLine  in  MEMORY_LINE_BITS  read data.
- memRValid  in  1  read-complete pulse.
- memWAck  in  1  write-complete pulse.
- errTimeout  out  1  sticky timeout flag.

Behaviour:
- States: IDLE, IREAD, DREAD, DWRITE. All are registered.
- Reset is asynchronous: state=IDLE, rrLast=I (so D wins the first tie), counter=0, errTimeout=0. memAddr/memWLine registers=0.
- Every output is 0 during reset.
- IDLE arbitration is evaluated each cycle, highest priority first:
  - dWriteReq -> DWRITE.
  - Otherwise, if both read requests are high: round-robin, granting the requester not equal to rrLast.
  - Otherwise, a single read request is granted.
- On grant, capture the address with the low OFFSET_BITS forced to 0. For DWRITE, also capture dWriteLine. Update rrLast on read grants only. Clear the counter.
- Busy states (IREAD/DREAD/DWRITE):
  - memReq=1.
  - memWE=1 only in DWRITE.
  - memAddr/memWLine are driven from the captured registers, stable for the whole transaction.
- IDLE outputs: memReq=0, memWE=0.
- Completion:
  - IREAD: memRValid -> iReadLineValid=1 and iReadLine=memRLine in the same cycle (combinational passthrough gated by state).
  - DREAD: memRValid -> the d-read equivalents.
  - DWRITE: memWAck -> dWriteAck=1.
  - Next state after completion is IDLE.
- Grant latency:
  - Request visible in cycle N -> memReq=1 in N+1.
  - Completion in cycle M -> IDLE in M+1. Earliest next grant is evaluated in M+1, so there is at least one memReq-low cycle between transactions. This lets the owner drop its level request.
- Line buses iReadLine/dReadLine carry memRLine unconditionally; only the valid pulses are gated.
- Ignored pulses:
  - memRValid/memWAck in IDLE.
  - memWAck in a read state; memRValid in DWRITE.
  - No valid pulse is emitted for any of these.
- If a requester drops its request mid-transaction, the transaction still completes and the pulse is still emitted.
- Counter: increments every busy cycle without completion. When it reaches TIMEOUT_CYCLES:
  - Go to IDLE and set errTimeout.
  - No completion pulse is emitted. The requester re-requests naturally, since its request is level.
  - errTimeout clears only on rst.
- Asynchronous reset mid-transaction: memReq drops immediately; no pulse is emitted.

Decomposition:
- Shared package:
  - state encoding (2 bits: IDLE=0, IREAD=1, DREAD=2, DWRITE=3);
  - requester IDs;
  - proc-level ARCH_BITS/MEMORY_LINE_BITS constants;
  - a line-align helper.
- Single module; no sub-module needed. The timeout counter is inline.

Test Plan:
- Reset, then iReadReq=1 with iReadAddr=0x00001234 -> memReq=1, memWE=0, memAddr=0x00001230 the next cycle. memRValid with memRLine=0xA5..A5 three cycles later -> iReadLineValid one cycle, iReadLine=0xA5..A5, dReadLineValid=0.
- iReadReq and dReadReq raised together, both held across two transactions -> grant order D then I. A third tie after that -> D.
- dWriteReq (addr 0x40, line 0x1122..) together with dReadReq -> DWRITE first with memWE=1, memWLine=0x1122... memWAck -> dWriteAck pulse, one IDLE cycle, then DREAD.
- Spurious memRValid in IDLE, and memWAck during IREAD -> no valid pulses; IREAD remains until memRValid.
- No memory response for 255 busy cycles -> return to IDLE, errTimeout=1 (sticky), no valid pulse; the next request is regranted normally.
- Assert rst mid-DREAD -> memReq=0 the same cycle, errTimeout=0, no dReadLineValid. After release, the held dReadReq is regranted.
